load_store_unit: RTL and testbench

// Executes one load or store per transaction, using the 3-bit width code from the

---
 rtl/load_store_unit_if.sv | 49 ++++
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bus bundle for the load/store unit.
// Carries the core-side request/response handshake and the word-addressed
// data-memory port.
//   master : the environment side (core execute stage + data memory); drives
//            requests, memory grant/read data, and observes responses.
//   slave  : the load/store unit itself.
// Signals:
//   req_valid/req_ready/req_store/req_ctrl/req_addr/req_wdata  core request
//   rsp_valid/rsp_rdata/rsp_err                                core response
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata                   memory request
//   mem_gnt/mem_rvalid/mem_rdata                               memory reply
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_ctrl;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output req_valid, req_store, req_ctrl, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  req_valid, req_store, req_ctrl, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: executes one load or store per transaction between the
// core execute stage and a word-addressed data memory.
//   Stores: byte enables from the width code and address lane, write data
//           replicated across lanes.
//   Loads:  addressed lane extracted, sign- or zero-extended.
//   Errors: misaligned access, illegal width code, memory timeout.
// Width codes: 1=byte, 2=half, 3=word, 4=byte-unsigned, 5=half-unsigned.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    load_store_unit_if.slave (request, response and memory signals)
// Parameters:
//   ADDR_WIDTH      byte address width
//   DATA_WIDTH      data width, fixed at 32
//   TIMEOUT_CYCLES  max cycles spent in REQ+WAIT before an error response
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit_if.slave    bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             store_q;
  logic [2:0]       ctrl_q;
  logic [1:0]       lane_q;

  // A request that can never reach memory: unknown code, unsigned store,
  // or an address not aligned to the access size.
  function automatic logic is_legal(input logic store, input logic [2:0] ctrl,
                                    input logic [1:0] lane);
    case (ctrl)
      3'd1:    is_legal = 1'b1;
      3'd2:    is_legal = ~lane[0];
      3'd3:    is_legal = (lane == 2'b00);
      3'd4:    is_legal = ~store;
      3'd5:    is_legal = ~store & ~lane[0];
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] ctrl, input logic [1:0] lane);
    case (ctrl)
      3'd1:    store_be = 4'b0001 << lane;
      3'd2:    store_be = lane[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_data(input logic [2:0] ctrl,
                                                       input logic [DATA_WIDTH-1:0] wdata);
    case (ctrl)
      3'd1:    store_data = {4{wdata[7:0]}};
      3'd2:    store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] ctrl,
                                                        input logic [1:0] lane,
                                                        input logic [DATA_WIDTH-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (ctrl)
      3'd1:    load_extend = {{24{b[7]}}, b};
      3'd2:    load_extend = {{16{h[15]}}, h};
      3'd4:    load_extend = {24'd0, b};
      3'd5:    load_extend = {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      store_q       <= 1'b0;
      ctrl_q        <= 3'd0;
      lane_q        <= 2'd0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= 4'b0000;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        // Accept and latch one request; illegal ones skip memory entirely.
        IDLE: begin
          tmo_cnt <= '0;
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            store_q       <= bus.req_store;
            ctrl_q        <= bus.req_ctrl;
            lane_q        <= bus.req_addr[1:0];
            if (is_legal(bus.req_store, bus.req_ctrl, bus.req_addr[1:0])) begin
              state         <= REQ;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.req_store;
              bus.mem_addr  <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
              bus.mem_be    <= bus.req_store ? store_be(bus.req_ctrl, bus.req_addr[1:0])
                                             : 4'b1111;
              bus.mem_wdata <= bus.req_store ? store_data(bus.req_ctrl, bus.req_wdata)
                                             : '0;
            end else begin
              // rsp_valid is raised from RESP one cycle later, keeping the
              // error response two cycles after acceptance.
              state       <= RESP;
              bus.rsp_err <= 1'b1;
            end
          end
        end
        // Hold the memory request until granted; gnt wins over timeout.
        REQ: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            if (store_q) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
            end else if (bus.mem_rvalid) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= load_extend(ctrl_q, lane_q, bus.mem_rdata);
            end else begin
              state <= WAIT;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state         <= RESP;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
          end
        end
        // Load granted, waiting for read data; the timeout budget carries over.
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (bus.mem_rvalid) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= load_extend(ctrl_q, lane_q, bus.mem_rdata);
          end else if (tmo_cnt == TMO_LAST) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
          end
        end
        // One-cycle response strobe; rdata/err are cleared on the way out.
        RESP: begin
          if (!bus.rsp_valid) begin
            bus.rsp_valid <= 1'b1;
          end else begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed transactions with an abstract
// model of expected memory-port and response behaviour per relative cycle.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expectations for the transaction in flight; rel counts cycles after
  // the acceptance edge (rel=0 is the cycle right after it).
  bit          active = 1'b0;
  int          rel;
  bit          e_st, e_legal, e_err;
  logic [31:0] e_addr, e_wd, e_rd;
  logic [3:0]  e_be;
  int          e_req_last, e_rsp_rel;
  bit          lit_en;
  logic [3:0]  l_be;
  logic [31:0] l_wd, l_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Access size in bytes for a width code, 0 when the code is unknown.
  function automatic int msize(input logic [2:0] c);
    case (c)
      3'd1, 3'd4: return 1;
      3'd2, 3'd5: return 2;
      3'd3:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit mlegal(input bit st, input logic [2:0] c, input logic [31:0] a);
    int s;
    s = msize(c);
    if (s == 0) return 1'b0;
    if (st && (c > 3'd3)) return 1'b0;
    return (int'(a[1:0]) % s) == 0;
  endfunction

  function automatic logic [3:0] mbe(input bit st, input logic [2:0] c, input logic [31:0] a);
    int s;
    if (!st) return 4'hF;
    s = msize(c);
    return 4'(((1 << s) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] mwd(input logic [2:0] c, input logic [31:0] wd);
    longint v;
    case (msize(c))
      1:       v = longint'(wd[7:0]) * 64'h0101_0101;
      2:       v = longint'(wd[15:0]) * 64'h0001_0001;
      default: v = longint'(wd);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] mrd(input logic [2:0] c, input logic [31:0] a,
                                      input logic [31:0] word);
    longint v;
    int s, off;
    s   = msize(c);
    off = int'(a[1:0]);
    v = (longint'(word) >> (8 * off)) & ((longint'(1) << (8 * s)) - 1);
    if ((c == 3'd1 || c == 3'd2) && v >= (longint'(1) << (8 * s - 1)))
      v = v - (longint'(1) << (8 * s));
    return v[31:0];
  endfunction

  // Single compare process: memory port and response against the model.
  always @(negedge clk) begin
    if (active) begin
      if (e_legal && (rel <= e_req_last)) begin
        chk("mem_req", bus.mem_req, 1);
        chk("mem_we", bus.mem_we, e_st);
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_be", bus.mem_be, e_be);
        if (e_st) chk("mem_wdata", bus.mem_wdata, e_wd);
        if (lit_en) begin
          chk("lit_mem_be", bus.mem_be, l_be);
          if (e_st) chk("lit_mem_wdata", bus.mem_wdata, l_wd);
        end
      end else begin
        chk("mem_req_idle", bus.mem_req, 0);
      end
      chk("rsp_valid", bus.rsp_valid, (rel == e_rsp_rel));
      if (rel == e_rsp_rel) begin
        chk("rsp_err", bus.rsp_err, e_err);
        chk("rsp_rdata", bus.rsp_rdata, e_rd);
        if (lit_en) chk("lit_rsp_rdata", bus.rsp_rdata, l_rd);
      end
      chk("req_ready", bus.req_ready, (rel > e_rsp_rel));
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 0);
    chk({tag, "_mem_req"}, bus.mem_req, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_be"}, bus.mem_be, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  // gd: cycles after acceptance before mem_gnt; rd: further cycles to
  // mem_rvalid on loads (0 = same cycle as gnt).
  task automatic run_txn(input bit st, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] word,
                         input int gd, input int rd, input bit len,
                         input logic [3:0] lbe, input logic [31:0] lwd, input logic [31:0] lrd);
    int e;
    int n;
    e_st    = st;
    e_legal = mlegal(st, ctrl, addr);
    e_addr  = addr & 32'hFFFF_FFFC;
    e_be    = mbe(st, ctrl, addr);
    e_wd    = mwd(ctrl, wd);
    e = 1 + gd + (st ? 0 : rd);
    if (!e_legal) begin
      e_rsp_rel = 1;   e_err = 1'b1;
    end else if (e > TMO) begin
      e_rsp_rel = TMO; e_err = 1'b1;
    end else begin
      e_rsp_rel = e;   e_err = 1'b0;
    end
    e_req_last = (gd < TMO) ? gd : TMO - 1;
    e_rd   = (e_err || st) ? 32'd0 : mrd(ctrl, addr, word);
    lit_en = len; l_be = lbe; l_wd = lwd; l_rd = lrd;

    @(posedge clk); #1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) begin
      chk("req_ready_wait", bus.req_ready, 1);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_store = st;
    bus.req_ctrl  = ctrl;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.mem_rdata = word;
    @(posedge clk); #1;
    active = 1'b1;
    for (int r = 0; r <= e_rsp_rel + 1; r++) begin
      rel = r;
      // A conflicting request while busy must be ignored.
      bus.req_valid  = (r < e_rsp_rel);
      bus.req_store  = ~st;
      bus.req_ctrl   = 3'd3;
      bus.req_addr   = 32'h0000_5554;
      bus.req_wdata  = 32'hFFFF_FFFF;
      bus.mem_gnt    = (r == gd);
      bus.mem_rvalid = !st && (r == gd + rd);
      @(posedge clk); #1;
    end
    active = 1'b0;
    bus.req_valid  = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_ctrl   = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // sb / loads with the vectors worked out by hand
    run_txn(1, 3'd1, 32'h0000_1002, 32'h0000_00A5, 32'd0, 0, 0, 1, 4'b0100, 32'hA5A5_A5A5, 32'd0);
    run_txn(0, 3'd1, 32'h0000_2003, 32'd0, 32'h80FF_1234, 0, 0, 1, 4'b1111, 32'd0, 32'hFFFF_FF80);
    run_txn(0, 3'd4, 32'h0000_2003, 32'd0, 32'h80FF_1234, 0, 0, 1, 4'b1111, 32'd0, 32'h0000_0080);
    run_txn(0, 3'd2, 32'h0000_2002, 32'd0, 32'h8001_7FFF, 1, 1, 1, 4'b1111, 32'd0, 32'hFFFF_8001);
    run_txn(0, 3'd5, 32'h0000_2002, 32'd0, 32'h8001_7FFF, 0, 2, 1, 4'b1111, 32'd0, 32'h0000_8001);
    run_txn(0, 3'd3, 32'h0000_2000, 32'd0, 32'h8001_7FFF, 2, 0, 1, 4'b1111, 32'd0, 32'h8001_7FFF);
    run_txn(0, 3'd1, 32'h0000_4000, 32'd0, 32'h1234_567F, 0, 0, 1, 4'b1111, 32'd0, 32'h0000_007F);
    run_txn(0, 3'd2, 32'h0000_4000, 32'd0, 32'hABCD_7FFE, 0, 1, 0, 4'h0, 32'd0, 32'd0);
    // store lanes, including a grant on the last cycle before timeout
    run_txn(1, 3'd2, 32'h0000_1006, 32'h1234_BEEF, 32'd0, 1, 0, 1, 4'b1100, 32'hBEEF_BEEF, 32'd0);
    run_txn(1, 3'd2, 32'h0000_1004, 32'h0000_C0DE, 32'd0, 0, 0, 1, 4'b0011, 32'hC0DE_C0DE, 32'd0);
    run_txn(1, 3'd3, 32'h0000_1008, 32'hDEAD_BEEF, 32'd0, 3, 0, 1, 4'b1111, 32'hDEAD_BEEF, 32'd0);
    run_txn(1, 3'd1, 32'h0000_1001, 32'h0000_0033, 32'd0, 0, 0, 0, 4'h0, 32'd0, 32'd0);
    // illegal requests
    run_txn(1, 3'd3, 32'h0000_3001, 32'h1111_1111, 32'd0, 0, 0, 0, 4'h0, 32'd0, 32'd0);
    run_txn(1, 3'd4, 32'h0000_3000, 32'h1111_1111, 32'd0, 0, 0, 0, 4'h0, 32'd0, 32'd0);
    run_txn(1, 3'd5, 32'h0000_3000, 32'h1111_1111, 32'd0, 0, 0, 0, 4'h0, 32'd0, 32'd0);
    run_txn(0, 3'd0, 32'h0000_3000, 32'd0, 32'h5555_5555, 0, 0, 0, 4'h0, 32'd0, 32'd0);
    run_txn(0, 3'd6, 32'h0000_3000, 32'd0, 32'h5555_5555, 0, 0, 0, 4'h0, 32'd0, 32'd0);
    run_txn(0, 3'd7, 32'h0000_3000, 32'd0, 32'h5555_5555, 0, 0, 0, 4'h0, 32'd0, 32'd0);
    run_txn(0, 3'd2, 32'h0000_2001, 32'd0, 32'h5555_5555, 0, 0, 0, 4'h0, 32'd0, 32'd0);
    run_txn(0, 3'd3, 32'h0000_2002, 32'd0, 32'h5555_5555, 0, 0, 0, 4'h0, 32'd0, 32'd0);

    // grant never arrives: timeout, then a late rvalid/gnt must be ignored
    run_txn(1, 3'd3, 32'h0000_1000, 32'h0BAD_F00D, 32'd0, 100, 0, 0, 4'h0, 32'd0, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_gnt    = 1'b1;
    bus.mem_rdata  = 32'h7777_7777;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("late_rsp_valid", bus.rsp_valid, 0);
      chk("late_mem_req", bus.mem_req, 0);
      chk("late_req_ready", bus.req_ready, 1);
    end
    run_txn(0, 3'd3, 32'h0000_2000, 32'd0, 32'h8001_7FFF, 0, 0, 1, 4'b1111, 32'd0, 32'h8001_7FFF);
    // load granted but read data never comes: timeout in WAIT
    run_txn(0, 3'd3, 32'h0000_2000, 32'd0, 32'h1234_5678, 1, 10, 0, 4'h0, 32'd0, 32'd0);

    // asynchronous reset while waiting for load data
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_store = 1'b0;
    bus.req_ctrl  = 3'd3;
    bus.req_addr  = 32'h0000_2000;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.mem_gnt   = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    chk("wait_mem_req", bus.mem_req, 0);
    chk("wait_mem_addr", bus.mem_addr, 32'h0000_2000);
    chk("wait_req_ready", bus.req_ready, 0);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_wait");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h9999_9999;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", bus.rsp_valid, 0);
      chk("post_rst_req_ready", bus.req_ready, 1);
    end
    run_txn(0, 3'd1, 32'h0000_2001, 32'd0, 32'h0000_8000, 0, 0, 0, 4'h0, 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
